// File: rtl/sr_div.sv
// Sequential restoring divider: 10-bit unsigned dividend by 5-bit unsigned divisor.
// One quotient bit per clock in CALC, with a single-cycle DONE pulse and a short path for divide-by-zero.
module sr_div (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] dividend,
    input  logic [4:0] divisor,
    output logic       busy,
    output logic       done,
    output logic       dz,
    output logic [9:0] quotient,
    output logic [4:0] remainder
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] q_q, q_d;
    logic [4:0] d_q, d_d;
    logic [5:0] r_q, r_d;
    logic [3:0] cnt_q, cnt_d;
    logic       dz_q, dz_d;
    logic [9:0] quot_q, quot_d;
    logic [4:0] rem_q, rem_d;

    logic [5:0] r_shift_s;
    logic [6:0] trial_s;
    logic       trial_ok_s;
    logic [5:0] r_step_s;
    logic [9:0] q_step_s;
    logic       unused_r_msb_s;

    // R stays below the divisor between steps, so its top bit never carries into the shift.
    assign unused_r_msb_s = r_q[5];

    // One restoring step; the extra borrow bit of the trial gives the sign.
    always_comb begin
        r_shift_s  = {r_q[4:0], q_q[9]};
        trial_s    = {1'b0, r_shift_s} - {2'b00, d_q};
        trial_ok_s = ~trial_s[6];
        if (trial_ok_s) begin
            r_step_s = trial_s[5:0];
        end else begin
            r_step_s = r_shift_s;
        end
        q_step_s = {q_q[8:0], trial_ok_s};
    end

    // Next-state and datapath update for the three-state controller.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = 6'd0;
                    cnt_d = 4'd0;
                    if (divisor == 5'd0) begin
                        dz_d    = 1'b1;
                        quot_d  = 10'h3FF;
                        rem_d   = dividend[4:0];
                        state_d = ST_DONE;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                q_d   = q_step_s;
                r_d   = r_step_s;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    quot_d  = q_step_s;
                    rem_d   = r_step_s[4:0];
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including held results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            q_q     <= 10'd0;
            d_q     <= 5'd0;
            r_q     <= 6'd0;
            cnt_q   <= 4'd0;
            dz_q    <= 1'b0;
            quot_q  <= 10'd0;
            rem_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy      = (state_q == ST_CALC);
    assign done      = (state_q == ST_DONE);
    assign dz        = dz_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: doc/sr_div.md
SR_DIV -- requirements
Module: sr_div

Interface
REQ-001 The block SHALL have a single clock domain, with reset asynchronous and active-low.
REQ-002 Port `clk`, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 Port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port `start`, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 Port `dividend`, input, 10 bits: unsigned numerator; captured on accepted start.
REQ-006 Port `divisor`, input, 5 bits: unsigned denominator; captured on accepted start.
REQ-007 Port `busy`, output, 1 bit: high while in CALC.
REQ-008 Port `done`, output, 1 bit: one-cycle pulse; results are valid.
REQ-009 Port `dz`, output, 1 bit: divide-by-zero flag for the last operation; held until the next accepted start.
REQ-010 Port `quotient`, output, 10 bits: result; held until the next accepted start.
REQ-011 Port `remainder`, output, 5 bits: result; held until the next accepted start.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 IDLE with start=1 at an edge SHALL cause the following on that edge:
- capture dividend into a 10-bit shift register Q;
- capture divisor into a 5-bit register D;
- clear the 6-bit partial remainder R;
- clear the 4-bit step counter;
- clear dz;
- go to CALC.
REQ-014 IDLE with start=1 and divisor=0 SHALL instead set dz=1, quotient=10'h3FF and remainder=dividend[4:0], then go directly to DONE.
REQ-015 Each CALC edge SHALL perform one restoring step:
- shift {R,Q} left by 1 (R[0] takes Q[9]);
- compute trial = shifted R − {1'b0,D} at 6-bit width;
- if trial is non-negative, set R = trial and Q[0] = 1;
- otherwise keep the shifted R and set Q[0] = 0;
- increment the step counter.
REQ-016 CALC SHALL last exactly 10 edges; on the edge where the counter reaches 9, the block SHALL load quotient=Q (final), remainder=R[4:0], and go to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally on the next edge.
REQ-018 Latency SHALL be:
- start accepted at edge N;
- done high in the cycle following edge N+10;
- for the divide-by-zero case, done high in the cycle following edge N.
REQ-019 start SHALL be ignored in CALC and DONE; operand changes during CALC SHALL have no effect.
REQ-020 busy SHALL equal (state==CALC), and done SHALL equal (state==DONE); both are decoded from registered state.
REQ-021 Results SHALL satisfy quotient*divisor + remainder = dividend, with remainder < divisor, for all divisor≠0.
REQ-022 R SHALL never exceed 6'd61; no overflow is permitted in the 6-bit trial subtraction.

Reset
REQ-023 When reset=0 at any time, including mid-CALC, the block SHALL immediately force:
- state=IDLE;
- busy=0, done=0, dz=0;
- quotient=0, remainder=0;
- R=0, Q=0, D=0, counter=0.
REQ-024 After reset is released, the first start SHALL behave as a fresh operation; no partial result SHALL survive reset.

Verification
REQ-025 Basic division: dividend=100, divisor=7, start pulse -> busy for 10 cycles, done pulse, then quotient=14, remainder=2, dz=0.
REQ-026 Maximum operands: dividend=1023, divisor=31 -> quotient=33, remainder=0, done 11 cycles after start was accepted.
REQ-027 Small dividend: dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-028 Divide by zero: dividend=300, divisor=0 -> done in the next cycle, busy never high, dz=1, quotient=10'h3FF, remainder=5'd12.
REQ-029 Ignored start: start 200/3; at CALC cycle 4, apply start with 50/5 and change the operand inputs -> result quotient=66, remainder=2 only, with a single done pulse.
REQ-030 Reset mid-operation: assert reset=0 at CALC cycle 6 -> all outputs 0 immediately; after release, 63/8 -> quotient=7, remainder=7.
